cache_refill_ctrl: RTL and testbench
====================================

CACHE_REFILL_CTRL -- requirements
Module: cache_refill_ctrl

Interface
REQ-001: The module SHALL have parameter DATA_WIDTH, default 32, giving the width of memory words and of req_addr/mem_addr.
REQ-002: The module SHALL have parameter CNT_WIDTH, default 16, giving the width of the miss counter.
REQ-003: Port clk, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-004: Port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005: Port req_valid, input, 1 bit: a CPU load access is present this cycle.
REQ-006: Port req_addr, input, DATA_WIDTH bits: the CPU byte address.
REQ-007: Port hit, input, 1 bit: the cache hit flag for req_addr.
REQ-008: Port stall, output, 1 bit: freeze request to the pipeline.
REQ-009: Port mem_req, output, 1 bit: word read request to main memory.
REQ-010: Port mem_addr, output, DATA_WIDTH bits: the word address of the current memory read.
REQ-011: Port mem_rvalid, input, 1 bit: mem_rdata is valid and the request is accepted.
REQ-012: Port mem_rdata, input, DATA_WIDTH bits: the returned memory word.
REQ-013: Port fill_we, output, 1 bit: one-cycle write strobe for the cache line.
REQ-014: Port fill_addr, output, DATA_WIDTH bits: the line-aligned address of the fill (supplies set and tag).
REQ-015: Ports d0, d1, d2, d3, output, DATA_WIDTH bits each: line words at offsets +0, +4, +8 and +12.
REQ-016: Port miss_count, output, CNT_WIDTH bits: number of misses serviced, saturating.

Function
REQ-017: The FSM SHALL have states IDLE, FETCH and WRITE, encoded in two bits, with IDLE as the reset state.
REQ-018: A miss SHALL be defined as req_valid=1 and hit=0 while the FSM is in IDLE.
REQ-019: In IDLE, stall SHALL be combinationally equal to the miss condition, so the pipeline freezes in the same cycle the miss is detected.
REQ-020: On a miss in IDLE, the block SHALL latch line_base={req_addr[31:4],4'b0}, clear word_cnt to 0, and enter FETCH on the next edge.
REQ-021: In IDLE with no miss, all outputs except miss_count and d0..d3 SHALL be 0.
REQ-022: In FETCH, stall=1 and mem_req=1 SHALL be held every cycle.
REQ-023: In FETCH, mem_addr SHALL equal line_base + 4*word_cnt, with word_cnt 2 bits wide.
REQ-024: In FETCH, only one request SHALL be outstanding at a time, and mem_addr SHALL be held until mem_rvalid=1.
REQ-025: In FETCH with mem_rvalid=1, mem_rdata SHALL be captured into d[word_cnt] and word_cnt SHALL increment.
REQ-026: In FETCH, if word_cnt=3 and mem_rvalid=1, the FSM SHALL move to WRITE instead of incrementing.
REQ-027: Memory wait states SHALL be unbounded, with no timeout.
REQ-028: mem_rvalid SHALL be ignored outside FETCH.
REQ-029: In WRITE, fill_we=1, stall=1, mem_req=0 and fill_addr=line_base SHALL hold for exactly one cycle.
REQ-030: In WRITE, d0..d3 SHALL hold the four captured words.
REQ-031: In WRITE, miss_count SHALL increment by 1 and saturate at all-ones.
REQ-032: From WRITE, the next state SHALL always be IDLE.
REQ-033: In the cycle after WRITE, the cache holds the line and hit=1 is expected, so stall drops and the access completes.
REQ-034: Minimum miss latency, from miss detection to stall low, SHALL be 6 cycles (1 IDLE + 4 FETCH + 1 WRITE) when mem_rvalid is 1 every cycle.
REQ-035: Changes on req_addr, req_valid or hit during FETCH or WRITE SHALL be ignored; the line address is latched.
REQ-036: fill_addr SHALL be 0 outside WRITE.
REQ-037: d0..d3 SHALL retain their values between fills.

Reset
REQ-038: With rst=1 at a clock edge, the state SHALL go to IDLE, and word_cnt, line_base, d0..d3 and miss_count SHALL go to 0.
REQ-039: Reset SHALL override any state, including mid-FETCH and WRITE.
REQ-040: An interrupted fill SHALL be abandoned with no fill_we pulse.
REQ-041: In the cycle after reset, stall=req_valid&~hit, and mem_req=0 and fill_we=0.

Verification
REQ-042: Scenario: req_valid=1, hit=0, req_addr=0x0000_1238, mem_rvalid=1 every cycle, mem_rdata=0xA0,0xA1,0xA2,0xA3 -> mem_addr=0x1230,0x1234,0x1238,0x123C; one fill_we with fill_addr=0x1230 and d0..d3=0xA0..0xA3; stall high for 6 cycles; miss_count=1.
REQ-043: Scenario: same miss with mem_rvalid low for 3 cycles before each word -> mem_addr held steady during each wait; stall high for 18 cycles; same fill data.
REQ-044: Scenario: req_valid=1, hit=1 -> stall=0, mem_req=0, fill_we=0, miss_count unchanged.
REQ-045: Scenario: rst=1 asserted in FETCH after 2 words captured -> next cycle in IDLE with stall=0 when req_valid=0, d0..d3=0, miss_count=0, no fill_we ever seen.
REQ-046: Scenario: req_addr changed to 0x0000_5000 during FETCH -> the fill still targets 0x1230.
REQ-047: Scenario: mem_rvalid=1 while in IDLE -> no state change and no capture.
REQ-048: Scenario: CNT_WIDTH=2 with 5 consecutive misses -> miss_count=3 and holds at 3.

Source files
------------

// File: rtl/cache_refill_ctrl.sv
// Blocking cache-line refill controller: on a load miss it fetches four
// words from memory one at a time, then writes the line into the cache.
module cache_refill_ctrl #(
   parameter int DATA_WIDTH = 32,
   parameter int CNT_WIDTH  = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  req_valid,
   input  logic [DATA_WIDTH-1:0] req_addr,
   input  logic                  hit,
   output logic                  stall,
   output logic                  mem_req,
   output logic [DATA_WIDTH-1:0] mem_addr,
   input  logic                  mem_rvalid,
   input  logic [DATA_WIDTH-1:0] mem_rdata,
   output logic                  fill_we,
   output logic [DATA_WIDTH-1:0] fill_addr,
   output logic [DATA_WIDTH-1:0] d0,
   output logic [DATA_WIDTH-1:0] d1,
   output logic [DATA_WIDTH-1:0] d2,
   output logic [DATA_WIDTH-1:0] d3,
   output logic [CNT_WIDTH-1:0]  miss_count
);

   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      FETCH = 2'b01,
      WRITE = 2'b10
   } state_t;

   localparam logic [DATA_WIDTH-1:0] OFFS_MASK = {{(DATA_WIDTH-4){1'b0}}, 4'b1111};
   localparam logic [CNT_WIDTH-1:0]  CNT_MAX   = {CNT_WIDTH{1'b1}};
   localparam logic [CNT_WIDTH-1:0]  CNT_ONE   = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

   state_t                  state_q, state_d;
   logic [1:0]              word_cnt_q, word_cnt_d;
   logic [DATA_WIDTH-1:0]   line_base_q, line_base_d;
   logic [DATA_WIDTH-1:0]   data_q [4];
   logic [DATA_WIDTH-1:0]   data_d [4];
   logic [CNT_WIDTH-1:0]    miss_cnt_q, miss_cnt_d;
   logic                    miss_s;

   assign miss_s = req_valid & ~hit;

   always_comb begin
      state_d     = state_q;
      word_cnt_d  = word_cnt_q;
      line_base_d = line_base_q;
      data_d      = data_q;
      miss_cnt_d  = miss_cnt_q;
      stall       = 1'b0;
      mem_req     = 1'b0;
      mem_addr    = {DATA_WIDTH{1'b0}};
      fill_we     = 1'b0;
      fill_addr   = {DATA_WIDTH{1'b0}};
      case (state_q)
         IDLE: begin
            // The pipeline must freeze in the very cycle the miss shows up.
            stall = miss_s;
            if (miss_s) begin
               line_base_d = req_addr & ~OFFS_MASK;
               word_cnt_d  = 2'd0;
               state_d     = FETCH;
            end else begin
               state_d = IDLE;
            end
         end
         FETCH: begin
            stall    = 1'b1;
            mem_req  = 1'b1;
            mem_addr = line_base_q + {{(DATA_WIDTH-4){1'b0}}, word_cnt_q, 2'b00};
            if (mem_rvalid) begin
               data_d[word_cnt_q] = mem_rdata;
               if (word_cnt_q == 2'd3) begin
                  state_d = WRITE;
               end else begin
                  word_cnt_d = word_cnt_q + 2'd1;
               end
            end else begin
               state_d = FETCH;
            end
         end
         WRITE: begin
            stall     = 1'b1;
            fill_we   = 1'b1;
            fill_addr = line_base_q;
            if (miss_cnt_q != CNT_MAX) begin
               miss_cnt_d = miss_cnt_q + CNT_ONE;
            end else begin
               miss_cnt_d = miss_cnt_q;
            end
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         word_cnt_q  <= 2'd0;
         line_base_q <= {DATA_WIDTH{1'b0}};
         data_q      <= '{default: {DATA_WIDTH{1'b0}}};
         miss_cnt_q  <= {CNT_WIDTH{1'b0}};
      end else begin
         state_q     <= state_d;
         word_cnt_q  <= word_cnt_d;
         line_base_q <= line_base_d;
         data_q      <= data_d;
         miss_cnt_q  <= miss_cnt_d;
      end
   end

   assign d0         = data_q[0];
   assign d1         = data_q[1];
   assign d2         = data_q[2];
   assign d3         = data_q[3];
   assign miss_count = miss_cnt_q;

endmodule

// File: tb/tb_cache_refill_ctrl.sv
// Scoreboard bench for cache_refill_ctrl: expected memory addresses and line
// fills are queued as misses are driven and matched as the DUT issues them.
module tb_cache_refill_ctrl;

   typedef struct packed {
      logic [31:0]       addr;
      logic [3:0][31:0]  d;
   } fill_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid;
   logic [31:0] req_addr;
   logic        hit;
   logic        stall;
   logic        mem_req;
   logic [31:0] mem_addr;
   logic        mem_rvalid;
   logic [31:0] mem_rdata;
   logic        fill_we;
   logic [31:0] fill_addr;
   logic [31:0] d0, d1, d2, d3;
   logic [15:0] miss_count;

   logic        s_stall, s_mem_req, s_fill_we;
   logic [31:0] s_mem_addr, s_fill_addr, s_d0, s_d1, s_d2, s_d3;
   logic [1:0]  s_miss_count;

   int          checks = 0;
   int          errors = 0;
   int          stall_cnt = 0;
   int          fill_cnt = 0;
   int          exp_cnt = 0;
   logic [3:0][31:0] exp_d;
   logic [31:0] exp_addr_q[$];
   fill_t       exp_fill_q[$];

   cache_refill_ctrl #(.DATA_WIDTH(32), .CNT_WIDTH(16)) u_dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_addr(req_addr), .hit(hit),
      .stall(stall), .mem_req(mem_req), .mem_addr(mem_addr),
      .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
      .fill_we(fill_we), .fill_addr(fill_addr),
      .d0(d0), .d1(d1), .d2(d2), .d3(d3), .miss_count(miss_count)
   );

   // Narrow-counter instance shares all stimulus to exercise saturation.
   cache_refill_ctrl #(.DATA_WIDTH(32), .CNT_WIDTH(2)) u_sat (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_addr(req_addr), .hit(hit),
      .stall(s_stall), .mem_req(s_mem_req), .mem_addr(s_mem_addr),
      .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
      .fill_we(s_fill_we), .fill_addr(s_fill_addr),
      .d0(s_d0), .d1(s_d1), .d2(s_d2), .d3(s_d3), .miss_count(s_miss_count)
   );

   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Monitor: matches memory requests and line fills against the scoreboard.
   always @(negedge clk) begin
      if (stall) stall_cnt++;
      if (mem_req && exp_addr_q.size() > 0) begin
         check_val("mem_addr", mem_addr, exp_addr_q[0]);
         if (mem_rvalid) void'(exp_addr_q.pop_front());
      end else if (mem_req && mem_rvalid) begin
         check_val("mem_req_unexpected", exp_addr_q.size(), 1);
      end
      if (fill_we) begin
         fill_cnt++;
         if (exp_fill_q.size() > 0) begin
            fill_t f;
            f = exp_fill_q.pop_front();
            check_val("fill_addr", fill_addr, f.addr);
            check_val("fill_d0", d0, f.d[0]);
            check_val("fill_d1", d1, f.d[1]);
            check_val("fill_d2", d2, f.d[2]);
            check_val("fill_d3", d3, f.d[3]);
            check_val("fill_stall", stall, 1);
            check_val("fill_mem_req", mem_req, 0);
         end else begin
            check_val("fill_unexpected", exp_fill_q.size(), 1);
         end
      end
   end

   task automatic do_miss(input logic [31:0] addr, input logic [31:0] dbase,
                          input int wt, input bit chg);
      int    s0, f0;
      fill_t f;
      s0 = stall_cnt;
      f0 = fill_cnt;
      f.addr = {addr[31:4], 4'b0000};
      for (int w = 0; w < 4; w++) begin
         exp_addr_q.push_back(f.addr + 32'(w * 4));
         f.d[w] = dbase + 32'(w);
      end
      exp_fill_q.push_back(f);
      req_valid = 1'b1; hit = 1'b0; req_addr = addr; mem_rvalid = 1'b0;
      step();
      if (chg) begin
         req_addr = 32'h0000_5000;
         hit = 1'b1;
      end
      for (int w = 0; w < 4; w++) begin
         for (int k = 0; k < wt; k++) begin
            mem_rvalid = 1'b0;
            mem_rdata  = 32'hBAD0_0000 + 32'(k);
            step();
         end
         mem_rvalid = 1'b1;
         mem_rdata  = dbase + 32'(w);
         step();
      end
      mem_rvalid = 1'b0;
      hit = 1'b1;
      step();
      exp_cnt++;
      exp_d = f.d;
      @(negedge clk);
      check_val("stall_after_fill", stall, 0);
      check_val("stall_cycles", 32'(stall_cnt - s0), 32'(6 + 4 * wt));
      check_val("fill_pulses", 32'(fill_cnt - f0), 1);
      check_val("miss_count", miss_count, 16'(exp_cnt));
      check_val("miss_count_sat", s_miss_count, (exp_cnt > 3) ? 2'd3 : 2'(exp_cnt));
      req_valid = 1'b0;
      hit = 1'b0;
   endtask

   initial begin
      int f0;
      rst = 1'b1; req_valid = 1'b1; hit = 1'b0; req_addr = 32'h0;
      mem_rvalid = 1'b0; mem_rdata = 32'h0;
      step();
      step();
      rst = 1'b0;
      @(negedge clk);
      check_val("rst_stall", stall, 1);
      check_val("rst_mem_req", mem_req, 0);
      check_val("rst_fill_we", fill_we, 0);
      check_val("rst_fill_addr", fill_addr, 0);
      check_val("rst_miss_count", miss_count, 0);
      check_val("rst_d0", d0, 0);
      req_valid = 1'b0;
      step();

      // Back-to-back memory responses
      do_miss(32'h0000_1238, 32'h0000_00A0, 0, 1'b0);

      // Hit: nothing happens
      req_valid = 1'b1; hit = 1'b1; req_addr = 32'h0000_1238;
      @(negedge clk);
      check_val("hit_stall", stall, 0);
      check_val("hit_mem_req", mem_req, 0);
      check_val("hit_mem_addr", mem_addr, 0);
      check_val("hit_fill_we", fill_we, 0);
      step();
      check_val("hit_miss_count", miss_count, 16'(exp_cnt));
      req_valid = 1'b0; hit = 1'b0;

      // mem_rvalid in IDLE is ignored
      mem_rvalid = 1'b1; mem_rdata = 32'hDEAD_BEEF;
      step();
      step();
      @(negedge clk);
      check_val("idle_rv_mem_req", mem_req, 0);
      check_val("idle_rv_stall", stall, 0);
      check_val("idle_rv_d0", d0, exp_d[0]);
      check_val("idle_rv_d3", d3, exp_d[3]);
      check_val("idle_rv_miss_count", miss_count, 16'(exp_cnt));
      mem_rvalid = 1'b0;
      step();

      // Reset in the middle of FETCH after two words
      f0 = fill_cnt;
      exp_addr_q.push_back(32'h0000_1230);
      exp_addr_q.push_back(32'h0000_1234);
      req_valid = 1'b1; hit = 1'b0; req_addr = 32'h0000_1238;
      step();
      req_valid = 1'b0;
      for (int w = 0; w < 2; w++) begin
         mem_rvalid = 1'b1; mem_rdata = 32'h0000_00B0 + 32'(w);
         step();
      end
      mem_rvalid = 1'b0;
      rst = 1'b1;
      step();
      rst = 1'b0;
      exp_cnt = 0;
      @(negedge clk);
      check_val("midrst_stall", stall, 0);
      check_val("midrst_mem_req", mem_req, 0);
      check_val("midrst_d0", d0, 0);
      check_val("midrst_d1", d1, 0);
      check_val("midrst_d2", d2, 0);
      check_val("midrst_d3", d3, 0);
      check_val("midrst_miss_count", miss_count, 0);
      repeat (4) step();
      check_val("midrst_no_fill", 32'(fill_cnt - f0), 0);

      // Three wait states before each word
      do_miss(32'h0000_1238, 32'h0000_00A0, 3, 1'b0);
      // Address and hit change mid-fetch are ignored
      do_miss(32'h0000_1238, 32'h0000_00C0, 1, 1'b1);
      // Further misses drive the narrow counter into saturation
      do_miss(32'h0000_2004, $urandom, 0, 1'b0);
      do_miss(32'h0000_3FFC, $urandom, 2, 1'b0);
      do_miss(32'hFFFF_FFF0, $urandom, 0, 1'b0);
      repeat (3) step();
      check_val("sat_hold", s_miss_count, 2'd3);
      check_val("addr_q_empty", exp_addr_q.size(), 0);
      check_val("fill_q_empty", exp_fill_q.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
